// File: rtl/lcd_rx_pkg.sv
// Shared types, opcode masks and DDRAM address helpers for the lcd_rx receiver.
package lcd_rx_pkg;

    typedef enum logic [1:0] {
        ST_MODE8,
        ST_HI,
        ST_LO
    } frame_t;

    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPCTL = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGADDR  = 8'h40;
    localparam logic [7:0] OP_DDADDR  = 8'h80;
    localparam logic [7:0] FUNC_MASK  = 8'hE0;

    localparam logic [6:0]  LINE0_BASE = 7'h00;
    localparam logic [6:0]  LINE1_BASE = 7'h40;
    localparam int unsigned LINE_LEN   = 40;
    localparam logic [6:0]  LINE_LAST  = 7'(LINE_LEN - 1);

    function automatic logic [6:0] lin(input logic [6:0] ac);
        return (ac >= LINE1_BASE) ? (ac - LINE1_BASE + 7'(LINE_LEN)) : ac;
    endfunction

    function automatic logic ac_valid(input logic [6:0] ac);
        return (ac <= LINE0_BASE + LINE_LAST) ||
               ((ac >= LINE1_BASE) && (ac <= LINE1_BASE + LINE_LAST));
    endfunction

    function automatic logic [6:0] ac_inc(input logic [6:0] ac);
        if (ac == LINE0_BASE + LINE_LAST) return LINE1_BASE;
        if (ac == LINE1_BASE + LINE_LAST) return LINE0_BASE;
        return ac + 7'd1;
    endfunction

    function automatic logic [6:0] ac_dec(input logic [6:0] ac);
        if (ac == LINE0_BASE) return LINE1_BASE + LINE_LAST;
        if (ac == LINE1_BASE) return LINE0_BASE + LINE_LAST;
        return ac - 7'd1;
    endfunction

    function automatic logic [5:0] ofs_step(input logic [5:0] ofs, input logic up);
        if (up) return (ofs == 6'(LINE_LEN - 1)) ? 6'd0 : ofs + 6'd1;
        return (ofs == 6'd0) ? 6'(LINE_LEN - 1) : ofs - 6'd1;
    endfunction

endpackage

// File: rtl/lcd_rx_strobe.sv
// Registers LCD_E/LCD_D, checks E pulse width and emits one pulse per falling edge
// carrying the {RS, nibble} seen in the last high cycle.
module lcd_rx_strobe
    import lcd_rx_pkg::*;
#(
    parameter int unsigned E_MIN_HIGH = 10
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [5:0] i_d,
    input  logic       i_e,
    output logic       o_stb,
    output logic       o_rs,
    output logic [3:0] o_nib,
    output logic       o_err
);

    localparam int unsigned CW = $clog2(E_MIN_HIGH + 1);

    logic          r_e, r_e_q;
    logic [5:0]    r_d, r_d_hold;
    logic [CW-1:0] r_cnt;
    logic          w_fall, w_long;

    assign w_fall = r_e_q & ~r_e;
    assign w_long = (r_cnt >= CW'(E_MIN_HIGH));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_e      <= 1'b0;
            r_e_q    <= 1'b0;
            r_d      <= '0;
            r_d_hold <= '0;
            r_cnt    <= '0;
            o_stb    <= 1'b0;
            o_rs     <= 1'b0;
            o_nib    <= '0;
            o_err    <= 1'b0;
        end else begin
            r_e   <= i_e;
            r_e_q <= r_e;
            r_d   <= i_d;
            // Count saturates at the threshold so long pulses never wrap back to "short".
            if (r_e) begin
                r_d_hold <= r_d;
                if (!w_long) r_cnt <= r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            o_stb <= w_fall & w_long & ~r_d_hold[4];
            o_err <= w_fall & (~w_long | r_d_hold[4]);
            o_rs  <= r_d_hold[5];
            o_nib <= r_d_hold[3:0];
        end
    end

endmodule

// File: rtl/lcd_rx.sv
// HD44780-style receiver for the 4-bit LCD bus: framing, instruction decode, busy and DDRAM writes.
// Optional macro LCD_RX_BUSY_CHECK_EN flags strobes accepted while the controller is busy.
module lcd_rx
    import lcd_rx_pkg::*;
#(
    parameter int unsigned E_MIN_HIGH = 10,
    parameter int unsigned BUSY_SHORT = 2000,
    parameter int unsigned BUSY_LONG  = 82000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] LCD_D,
    input  logic       LCD_E,
    output logic       ddr_we,
    output logic [6:0] ddr_addr,
    output logic [7:0] ddr_wdata,
    output logic       cmd_valid,
    output logic [7:0] cmd_byte,
    output logic       busy,
    output logic       mode_4bit,
    output logic       display_on,
    output logic       cursor_on,
    output logic       blink_on,
    output logic       two_line,
    output logic [5:0] shift_ofs,
    output logic       err
);

    localparam int unsigned BW = $clog2(BUSY_LONG + 1);

    logic          w_stb, w_rs, w_stb_err;
    logic [3:0]    w_nib;
    frame_t        r_state, w_state_nxt;
    logic          r_hi_rs;
    logic [3:0]    r_hi_nib;
    logic          w_take, w_drop, w_busy_err;
    logic          w_byte_vld, w_byte_rs, w_frame_err;
    logic [7:0]    w_byte;
    logic [6:0]    r_ac;
    logic          r_id, r_s;
    logic          r_sweep;
    logic [6:0]    r_sw_idx;
    logic [BW-1:0] r_busy_cnt;

    lcd_rx_strobe #(.E_MIN_HIGH(E_MIN_HIGH)) u_strobe (
        .i_clk   (clk),
        .i_rst_n (reset),
        .i_d     (LCD_D),
        .i_e     (LCD_E),
        .o_stb   (w_stb),
        .o_rs    (w_rs),
        .o_nib   (w_nib),
        .o_err   (w_stb_err)
    );

    assign w_take    = w_stb & ~r_sweep;
    assign w_drop    = w_stb & r_sweep;
    assign busy      = (r_busy_cnt != '0);
    assign mode_4bit = (r_state != ST_MODE8);

    // A strobe landing on the last busy cycle (count 1) is treated as on time.
`ifdef LCD_RX_BUSY_CHECK_EN
    assign w_busy_err = w_take & (r_busy_cnt > BW'(1));
`else
    assign w_busy_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_MODE8;
            r_hi_rs  <= 1'b0;
            r_hi_nib <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_take && r_state == ST_HI) begin
                r_hi_rs  <= w_rs;
                r_hi_nib <= w_nib;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_vld  = 1'b0;
        w_byte      = '0;
        w_byte_rs   = 1'b0;
        w_frame_err = 1'b0;
        if (w_take) begin
            case (r_state)
                ST_MODE8: begin
                    w_byte_vld = 1'b1;
                    w_byte     = {w_nib, 4'h0};
                    w_byte_rs  = w_rs;
                end
                ST_HI: w_state_nxt = ST_LO;
                ST_LO: begin
                    w_byte_vld  = 1'b1;
                    w_byte      = {r_hi_nib, w_nib};
                    w_byte_rs   = r_hi_rs;
                    w_frame_err = (w_rs != r_hi_rs);
                    w_state_nxt = ST_HI;
                end
                default: w_state_nxt = ST_MODE8;
            endcase
            if (w_byte_vld && !w_byte_rs && ((w_byte & FUNC_MASK) == OP_FUNC))
                w_state_nxt = w_byte[4] ? ST_MODE8 : ST_HI;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ddr_we     <= 1'b0;
            ddr_addr   <= '0;
            ddr_wdata  <= '0;
            cmd_valid  <= 1'b0;
            cmd_byte   <= '0;
            display_on <= 1'b0;
            cursor_on  <= 1'b0;
            blink_on   <= 1'b0;
            two_line   <= 1'b0;
            shift_ofs  <= '0;
            err        <= 1'b0;
            r_ac       <= '0;
            r_id       <= 1'b1;
            r_s        <= 1'b0;
            r_sweep    <= 1'b0;
            r_sw_idx   <= '0;
            r_busy_cnt <= '0;
        end else begin
            ddr_we    <= 1'b0;
            cmd_valid <= 1'b0;
            err       <= w_stb_err | w_drop | w_frame_err | w_busy_err;
            if (r_busy_cnt != '0) r_busy_cnt <= r_busy_cnt - BW'(1);

            if (r_sweep) begin
                ddr_we    <= 1'b1;
                ddr_addr  <= r_sw_idx;
                ddr_wdata <= 8'h20;
                r_sw_idx  <= r_sw_idx + 7'd1;
                if (r_sw_idx == 7'(2 * LINE_LEN - 1)) r_sweep <= 1'b0;
            end

            if (w_byte_vld) begin
                r_busy_cnt <= BW'(BUSY_SHORT);
                if (w_byte_rs) begin
                    ddr_we    <= 1'b1;
                    ddr_addr  <= lin(r_ac);
                    ddr_wdata <= w_byte;
                    r_ac      <= r_id ? ac_inc(r_ac) : ac_dec(r_ac);
                    if (r_s) shift_ofs <= ofs_step(shift_ofs, r_id);
                end else begin
                    cmd_valid <= 1'b1;
                    cmd_byte  <= w_byte;
                    // Highest set bit selects the instruction; later checks are shadowed.
                    if ((w_byte & OP_DDADDR) != '0) begin
                        if (ac_valid(w_byte[6:0])) begin
                            r_ac <= w_byte[6:0];
                        end else begin
                            r_ac <= '0;
                            err  <= 1'b1;
                        end
                    end else if ((w_byte & OP_CGADDR) != '0) begin
                        r_ac <= r_ac;
                    end else if ((w_byte & OP_FUNC) != '0) begin
                        two_line <= w_byte[3];
                    end else if ((w_byte & OP_SHIFT) != '0) begin
                        if (w_byte[3]) shift_ofs <= ofs_step(shift_ofs, w_byte[2]);
                        else           r_ac <= w_byte[2] ? ac_inc(r_ac) : ac_dec(r_ac);
                    end else if ((w_byte & OP_DISPCTL) != '0) begin
                        display_on <= w_byte[2];
                        cursor_on  <= w_byte[1];
                        blink_on   <= w_byte[0];
                    end else if ((w_byte & OP_ENTRY) != '0) begin
                        r_id <= w_byte[1];
                        r_s  <= w_byte[0];
                    end else if ((w_byte & OP_HOME) != '0) begin
                        r_ac       <= '0;
                        shift_ofs  <= '0;
                        r_busy_cnt <= BW'(BUSY_LONG);
                    end else if ((w_byte & OP_CLEAR) != '0) begin
                        r_ac       <= '0;
                        r_id       <= 1'b1;
                        shift_ofs  <= '0;
                        r_busy_cnt <= BW'(BUSY_LONG);
                        ddr_we     <= 1'b1;
                        ddr_addr   <= '0;
                        ddr_wdata  <= 8'h20;
                        r_sweep    <= 1'b1;
                        r_sw_idx   <= 7'd1;
                    end
                end
            end
        end
    end

endmodule
